// File: rtl/memwrite_checker_if.sv
// memwrite_checker_if: CPU write-port, signature-config and verdict signals of the checker
interface memwrite_checker_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int MW_W = 2,
  parameter int N_SIG = 4,
  parameter int CNT_W = 16
);
  localparam int IDX_W = N_SIG > 1 ? $clog2(N_SIG) : 1;
  logic [MW_W-1:0] memwrite;
  logic [ADDR_W-1:0] dataadr;
  logic [DATA_W-1:0] writedata;
  logic seq_mode;
  logic cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic cfg_valid;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_data;
  logic done;
  logic [1:0] result;
  logic [IDX_W-1:0] match_idx;
  logic stop;
  logic [CNT_W-1:0] wr_count;
  logic [CNT_W-1:0] cyc_count;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_data;
  modport master (
    output memwrite, dataadr, writedata, seq_mode, cfg_we, cfg_idx, cfg_valid, cfg_addr, cfg_data,
    input done, result, match_idx, stop, wr_count, cyc_count, last_addr, last_data
  );
  modport slave (
    input memwrite, dataadr, writedata, seq_mode, cfg_we, cfg_idx, cfg_valid, cfg_addr, cfg_data,
    output done, result, match_idx, stop, wr_count, cyc_count, last_addr, last_data
  );
endinterface

// File: rtl/memwrite_checker.sv
// memwrite_checker: compares CPU data-memory writes against a signature table and
// issues one sticky done/result verdict, with watchdog and drain-to-stop window
module memwrite_checker #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int MW_W = 2,
  parameter int N_SIG = 4,
  parameter int CNT_W = 16,
  parameter int TIMEOUT = 1000,
  parameter int DRAIN_CYC = 10
) (
  input logic clk,
  input logic reset,
  memwrite_checker_if.slave bus
);
  localparam int IDX_W = N_SIG > 1 ? $clog2(N_SIG) : 1;
  localparam logic [31:0] DRAIN_LAST = DRAIN_CYC > 0 ? 32'(DRAIN_CYC - 1) : 32'd0;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_e;
  state_e state_q, state_d;
  logic [N_SIG-1:0] vld_q;
  logic [ADDR_W-1:0] adr_q [N_SIG];
  logic [DATA_W-1:0] dat_q [N_SIG];
  logic [IDX_W-1:0] ptr_q, ptr_d, idx_q, idx_d, hit_idx, ptr_nx;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d, cyc_q, cyc_d;
  logic [ADDR_W-1:0] la_q, la_d;
  logic [DATA_W-1:0] ld_q, ld_d;
  logic [1:0] res_q, res_d;
  logic [31:0] drain_q, drain_d;
  logic done_q, done_d, stop, run, wr, hit, seq_ok, seq_last, pass, fail, tmo, verdict;
  // lowest valid matching entry wins: scan downwards so the last hit assigned is the lowest
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = N_SIG - 1; i >= 0; i--)
      if (vld_q[i] && adr_q[i] == bus.dataadr && dat_q[i] == bus.writedata) begin
        hit = 1'b1;
        hit_idx = IDX_W'(i);
      end
  end
  assign run = state_q == RUN;
  assign wr = run && |bus.memwrite;
  assign ptr_nx = ptr_q + 1'b1;
  assign seq_ok = vld_q[ptr_q] && adr_q[ptr_q] == bus.dataadr && dat_q[ptr_q] == bus.writedata;
  assign seq_last = ptr_q == IDX_W'(N_SIG - 1) || !vld_q[ptr_nx];
  assign pass = wr && (bus.seq_mode ? seq_ok && seq_last : hit);
  assign fail = wr && bus.seq_mode && !seq_ok;
  assign tmo = run && TIMEOUT != 0 && cyc_q == TMO_LAST;
  assign verdict = pass || fail || tmo;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= RUN;
      vld_q <= '0;
      for (int i = 0; i < N_SIG; i++) begin
        adr_q[i] <= '0;
        dat_q[i] <= '0;
      end
      ptr_q <= '0;
      idx_q <= '0;
      wr_cnt_q <= '0;
      cyc_q <= '0;
      la_q <= '0;
      ld_q <= '0;
      res_q <= '0;
      drain_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus.cfg_we) begin
        vld_q[bus.cfg_idx] <= bus.cfg_valid;
        adr_q[bus.cfg_idx] <= bus.cfg_addr;
        dat_q[bus.cfg_idx] <= bus.cfg_data;
      end
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      wr_cnt_q <= wr_cnt_d;
      cyc_q <= cyc_d;
      la_q <= la_d;
      ld_q <= ld_d;
      res_q <= res_d;
      drain_q <= drain_d;
      done_q <= done_d;
    end
  always_comb begin
    state_d = state_q;
    if (run && verdict)
      state_d = DRAIN_CYC == 0 ? HALT : DRAIN;
    else if (state_q == DRAIN && drain_q == DRAIN_LAST)
      state_d = HALT;
  end
  always_comb begin
    stop = state_q == HALT;
    drain_d = state_q == DRAIN ? drain_q + 32'd1 : drain_q;
    wr_cnt_d = wr && !(&wr_cnt_q) ? wr_cnt_q + 1'b1 : wr_cnt_q;
    cyc_d = run && !(&cyc_q) ? cyc_q + 1'b1 : cyc_q;
    la_d = wr ? bus.dataadr : la_q;
    ld_d = wr ? bus.writedata : ld_q;
    ptr_d = wr && bus.seq_mode && seq_ok && !seq_last ? ptr_nx : ptr_q;
    done_d = done_q || verdict;
    res_d = !verdict ? res_q : pass ? 2'b01 : fail ? 2'b10 : 2'b11;
    idx_d = !pass ? idx_q : bus.seq_mode ? ptr_q : hit_idx;
  end
  assign bus.done = done_q;
  assign bus.result = res_q;
  assign bus.match_idx = idx_q;
  assign bus.stop = stop;
  assign bus.wr_count = wr_cnt_q;
  assign bus.cyc_count = cyc_q;
  assign bus.last_addr = la_q;
  assign bus.last_data = ld_q;
endmodule

// File: tb/tb_memwrite_checker.sv
// tb_memwrite_checker: directed plus random scenarios; a per-edge reference model predicts
// each verdict, pushes it to a scoreboard, and a monitor checks it at done/stop
module tb_memwrite_checker;
  localparam int N = 4;
  localparam int IW = 2;
  localparam int TMO = 48;
  localparam int DRN = 10;
  typedef struct {
    bit cfg;
    int idx;
    bit v;
    logic [63:0] ca, cd;
    logic [1:0] mw;
    logic [63:0] a, d;
  } op_t;
  typedef struct {
    int res, idx, wr, cyc;
    logic [63:0] la, ld;
  } exp_t;
  logic clk = 0;
  logic reset = 1;
  int vectors = 0;
  int miscompares = 0;
  int edges = 0;
  exp_t sb[$];
  memwrite_checker_if #(.ADDR_W(64), .DATA_W(64), .MW_W(2), .N_SIG(N), .CNT_W(16)) bus ();
  memwrite_checker #(
    .ADDR_W(64), .DATA_W(64), .MW_W(2), .N_SIG(N), .CNT_W(16), .TIMEOUT(TMO), .DRAIN_CYC(DRN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) edges++;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
    end
  endtask
  function automatic op_t idl();
    op_t o;
    o = '{default: '0};
    o.a = {$urandom, $urandom};
    o.d = 64'($urandom_range(0, 3));
    return o;
  endfunction
  function automatic op_t cfg(input int i, input bit v, input logic [63:0] a, input logic [63:0] d);
    op_t o;
    o = '{default: '0};
    o.cfg = 1;
    o.idx = i;
    o.v = v;
    o.ca = a;
    o.cd = d;
    return o;
  endfunction
  function automatic op_t wrop(input logic [63:0] a, input logic [63:0] d, input logic [1:0] mw);
    op_t o;
    o = '{default: '0};
    o.mw = mw;
    o.a = a;
    o.d = d;
    return o;
  endfunction
  // behavioural reference: walk RUN edges 1..TMO, table updates land after that edge's compare
  function automatic exp_t model(input op_t s[$], input bit seq);
    exp_t e;
    op_t o;
    bit v[N];
    logic [63:0] a[N], d[N];
    int ptr = 0;
    e = '{default: 0};
    for (int k = 0; k < N; k++) begin
      v[k] = 0;
      a[k] = 0;
      d[k] = 0;
    end
    for (int t = 1; t <= TMO; t++) begin
      if (t <= s.size()) o = s[t-1];
      else o = '{default: '0};
      if (o.mw != 0) begin
        e.wr++;
        e.la = o.a;
        e.ld = o.d;
        if (!seq) begin
          for (int k = 0; k < N; k++)
            if (e.res == 0 && v[k] && a[k] == o.a && d[k] == o.d) begin
              e.res = 1;
              e.idx = k;
            end
        end else if (v[ptr] && a[ptr] == o.a && d[ptr] == o.d) begin
          if (ptr == N - 1 || !v[ptr+1]) begin
            e.res = 1;
            e.idx = ptr;
          end else ptr++;
        end else e.res = 2;
      end
      if (e.res == 0 && t == TMO) e.res = 3;
      if (e.res != 0) begin
        e.cyc = t;
        return e;
      end
      if (o.cfg) begin
        v[o.idx] = o.v;
        a[o.idx] = o.ca;
        d[o.idx] = o.cd;
      end
    end
    return e;
  endfunction
  task automatic drive(input op_t o);
    bus.cfg_we = o.cfg;
    bus.cfg_idx = IW'(o.idx);
    bus.cfg_valid = o.v;
    bus.cfg_addr = o.ca;
    bus.cfg_data = o.cd;
    bus.memwrite = o.mw;
    bus.dataadr = o.a;
    bus.writedata = o.d;
  endtask
  task automatic run(input op_t s[$], input bit seq, input bit drain_reset);
    int n;
    @(negedge clk);
    reset = 1;
    bus.seq_mode = seq;
    drive(idl());
    #1;
    chk("rst_done", 64'(bus.done), 0);
    chk("rst_result", 64'(bus.result), 0);
    chk("rst_match_idx", 64'(bus.match_idx), 0);
    chk("rst_stop", 64'(bus.stop), 0);
    chk("rst_wr_count", 64'(bus.wr_count), 0);
    chk("rst_cyc_count", 64'(bus.cyc_count), 0);
    chk("rst_last_addr", bus.last_addr, 0);
    chk("rst_last_data", bus.last_data, 0);
    @(negedge clk);
    sb.push_back(model(s, seq));
    reset = 0;
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
    end
    drive(idl());
    n = 0;
    if (drain_reset) begin
      while (!bus.done && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("done_seen", 64'(bus.done), 1);
      repeat (3) @(negedge clk);
      chk("stop_before_reset", 64'(bus.stop), 0);
      if (sb.size() != 0) void'(sb.pop_front());
    end else begin
      while (!bus.stop && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!bus.stop) begin
        vectors++;
        miscompares++;
        $display("FAIL stop_wait: stop still %0b after %0d cycles, expected 1", bus.stop, n);
        sb.delete();
      end
    end
  endtask
  // monitor: verdict checked when done rises, frozen state and drain length when stop rises
  bit pd = 0, ps = 0;
  int done_edge = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      pd = 0;
      ps = 0;
    end else begin
      if (bus.done && !pd) begin
        done_edge = edges;
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL done_unexpected: done=1 with no expectation queued");
        end else begin
          e = sb[0];
          chk("result", 64'(bus.result), 64'(e.res));
          if (e.res == 1) chk("match_idx", 64'(bus.match_idx), 64'(e.idx));
          chk("wr_count", 64'(bus.wr_count), 64'(e.wr));
          chk("cyc_count", 64'(bus.cyc_count), 64'(e.cyc));
          chk("last_addr", bus.last_addr, e.la);
          chk("last_data", bus.last_data, e.ld);
        end
      end
      if (bus.stop && !ps) begin
        chk("stop_gap", 64'(edges - done_edge), 64'(DRN));
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL stop_unexpected: stop=1 with no expectation queued");
        end else begin
          e = sb.pop_front();
          chk("frozen_result", 64'(bus.result), 64'(e.res));
          if (e.res == 1) chk("frozen_match_idx", 64'(bus.match_idx), 64'(e.idx));
          chk("frozen_wr_count", 64'(bus.wr_count), 64'(e.wr));
          chk("frozen_cyc_count", 64'(bus.cyc_count), 64'(e.cyc));
          chk("frozen_last_data", bus.last_data, e.ld);
        end
      end
      pd = bus.done;
      ps = bus.stop;
    end
  end
  initial begin
    op_t s[$];
    bit seq;
    bit v[N];
    logic [63:0] a[N], d[N];
    int j;
    drive(idl());
    bus.seq_mode = 0;
    s = {cfg(0, 1, 100, 7), wrop(96, 3, 1), wrop(100, 7, 2)};
    run(s, 0, 0);
    s = {cfg(0, 1, 508, 7), cfg(2, 1, 80, 1), wrop(80, 1, 3), idl(), wrop(508, 7, 1)};
    run(s, 0, 0);
    s = {cfg(0, 1, 0, 5), cfg(1, 1, 4, 6), cfg(2, 1, 80, 1), cfg(3, 0, 0, 0),
         wrop(0, 5, 1), wrop(4, 6, 1), idl(), wrop(80, 1, 1)};
    run(s, 1, 0);
    s = {cfg(0, 1, 0, 5), cfg(1, 1, 4, 6), cfg(2, 1, 80, 1), cfg(3, 0, 0, 0),
         wrop(0, 5, 1), wrop(4, 9, 2)};
    run(s, 1, 0);
    s = {};
    run(s, 0, 0);
    s = {cfg(0, 1, 100, 7)};
    repeat (46) s.push_back(idl());
    s.push_back(wrop(100, 7, 1));
    run(s, 0, 0);
    s = {cfg(0, 1, 100, 7), wrop(96, 3, 1), wrop(100, 7, 2)};
    run(s, 0, 1);
    s = {wrop(100, 7, 1), wrop(96, 3, 1)};
    run(s, 0, 0);
    for (int r = 0; r < 30; r++) begin
      seq = 1'($urandom_range(0, 1));
      s = {};
      for (int k = 0; k < N; k++) begin
        v[k] = $urandom_range(0, 3) != 0;
        a[k] = 64'(4 * $urandom_range(0, 3));
        d[k] = 64'($urandom_range(0, 3));
        s.push_back(cfg(k, v[k], a[k], d[k]));
      end
      j = 0;
      for (int w = $urandom_range(1, 10); w > 0; w--) begin
        repeat ($urandom_range(0, 2)) s.push_back(idl());
        if ($urandom_range(0, 2) != 0) begin
          if (!seq) j = $urandom_range(0, N - 1);
          s.push_back(wrop(a[j], d[j], 2'($urandom_range(1, 3))));
          j = (j + 1) % N;
        end else
          s.push_back(wrop(64'(4 * $urandom_range(0, 3)), 64'($urandom_range(0, 3)), 2'($urandom_range(1, 3))));
      end
      run(s, seq, 0);
    end
    chk("scoreboard_empty", 64'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
